// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int COUNT_W  = $clog2(MD_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift-add multiply / restoring divide engine.
// acc holds {upper, lower}: {partial product, multiplier} or {remainder, quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic                 i_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc_nxt,
  output logic                 o_q_bit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  // Both datapaths evaluated each cycle; mode picks the result. In divide
  // mode the quotient LSB is left 0 here and filled from o_q_bit by the owner.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_trial = i_acc[2*WIDTH-1:WIDTH-1];
    // When trial >= divisor the difference is below the divisor, so the
    // modulo-2^WIDTH subtraction is exact.
    w_diff  = w_trial[WIDTH-1:0] - i_operand;
    o_q_bit = i_div & (w_trial >= {1'b0, i_operand});
    if (i_div) begin
      o_acc_nxt = {(o_q_bit ? w_diff : w_trial[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc_nxt = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer writing architectural HI/LO.
//
// state     | meaning
// ST_IDLE   | waiting for start; HI/LO hold last result
// ST_RUN    | one engine step per cycle, count 0..WIDTH-1
// ST_FINISH | sign-correct and write HI/LO, pulse done
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall_req,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_t               r_state;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_dz;
  logic                 r_div_zero;
  logic [COUNT_W-1:0]   r_count;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_div_in;
  logic                 w_signed_in;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_q_bit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_hi_fin;
  logic [WIDTH-1:0]     w_lo_fin;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (r_is_div),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc_nxt (w_acc_nxt),
    .o_q_bit   (w_q_bit)
  );

  // Operand magnitudes at accept; unsigned ops pass through untouched.
  always_comb begin
    w_div_in    = op_is_div(i_op);
    w_signed_in = op_is_signed(i_op);
    w_a_abs     = (w_signed_in && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
    w_b_abs     = (w_signed_in && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;
  end

  // Sign correction of the finished engine result into HI/LO values.
  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fin = w_prod[WIDTH-1:0];
    if (r_dz) begin
      w_hi_fin = r_acc[2*WIDTH-1:WIDTH];
      w_lo_fin = '1;
    end else if (r_is_div) begin
      w_lo_fin = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_hi_fin = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer FSM, counter, engine registers and HI/LO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_div_zero <= 1'b0;
      r_count    <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_flush) begin
            r_is_div   <= w_div_in;
            r_neg_res  <= w_signed_in & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
            r_neg_rem  <= w_signed_in & i_src_a[WIDTH-1];
            r_count    <= '0;
            r_div_zero <= 1'b0;
            if (w_div_in && (i_src_b == '0)) begin
              // Divide by zero skips the engine; raw dividend goes to HI.
              r_dz    <= 1'b1;
              r_opnd  <= '0;
              r_acc   <= {i_src_a, {WIDTH{1'b0}}};
              r_state <= ST_FINISH;
            end else begin
              r_dz    <= 1'b0;
              r_opnd  <= w_div_in ? w_b_abs : w_a_abs;
              r_acc   <= {{WIDTH{1'b0}}, (w_div_in ? w_a_abs : w_b_abs)};
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= r_is_div ? {w_acc_nxt[2*WIDTH-1:1], w_q_bit} : w_acc_nxt;
            r_count <= r_count + 1'b1;
            if (r_count == COUNT_W'(WIDTH - 1)) r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          if (!i_flush) begin
            r_hi <= w_hi_fin;
            r_lo <= w_lo_fin;
            if (r_dz) r_div_zero <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status is a pure decode of registered state; done is masked by a
  // same-cycle flush so an aborted FINISH never reports completion.
  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    o_stall_req = o_busy;
    o_done      = (r_state == ST_FINISH) && !i_flush;
    o_div_zero  = r_div_zero;
    o_hi        = r_hi;
    o_lo        = r_lo;
  end

endmodule
